mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Parametrised MEM stage plus MEM/WB pipeline register for the RISC-V pipeline core; successor to the fixed single-cycle memory stage.
- Adds the following on top of the plain MEM/WB register:
  - byte/half/word stores with byte enables
  - sign/zero-extended sub-word loads
  - req/ready handshake to an external, variable-latency data memory
  - pipeline stall output
  - WB flush
  - access timeout with bus-error flag
- Sits between the execute-cycle outputs and the writeback mux; data width is fixed at 32.

Parameters:
- REG_ADDR_W, 5, register index width.
- RES_SRC_W, 2, ResultSrc width (00 ALU, 01 load, 10 PC+4).
- ADDR_W, 32, dmem address width (12..32); dmem_addr = alu_result_m[ADDR_W-1:0] with bits [1:0] forced to 0.
- TIMEOUT_CYC, 16, maximum wait cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- valid_m  in  1  instruction in MEM is valid
- reg_write_m  in  1  register write enable
- result_src_m  in  RES_SRC_W  result select
- mem_read_m  in  1  load
- mem_write_m  in  1  store
- funct3_m  in  3  access size/sign
- alu_result_m  in  32  address / ALU result
- write_data_m  in  32  store data
- rd_m  in  REG_ADDR_W  destination register
- pc_plus4_m  in  32  PC+4
- flush_w  in  1  squash the entry being loaded into MEM/WB
- dmem_req  out  1  access request
- dmem_we  out  1  write strobe
- dmem_addr  out  ADDR_W  word-aligned address
- dmem_wdata  out  32  lane-aligned store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete (read data valid on the same cycle)
- dmem_rdata  in  32  read word
- stall_m  out  1  freeze IF..MEM stages
- valid_w, reg_write_w  out  1  WB controls
- result_src_w  out  RES_SRC_W
- alu_result_w, read_data_w, pc_plus4_w  out  32
- rd_w  out  REG_ADDR_W
- bus_err_w  out  1  access timed out

Behaviour:
- Reset (asynchronous, rst=0): all W outputs = 0, state = IDLE, wait counter = 0, dmem_req = 0.
- acc = valid_m & (mem_read_m | mem_write_m).
- FSM IDLE:
  - dmem_req = acc, driven combinationally from the M inputs.
  - acc & dmem_ready: zero-wait completion; W loads this cycle's results.
  - acc & !dmem_ready: capture addr, wdata, be, we, funct3, ctrl, rd, pc_plus4 into hold regs; go to WAIT; counter = 1.
  - !acc: W loads M inputs directly (1-cycle latency).
- FSM WAIT:
  - dmem_req = 1; all dmem outputs driven from the hold regs and stable until ready.
  - dmem_ready: W loads the held entry plus formatted rdata; go to IDLE.
  - Timeout (TIMEOUT_CYC > 0, counter == TIMEOUT_CYC, no ready): W loads the held entry with reg_write_w = 0, bus_err_w = 1, valid_w = 1; go to IDLE.
  - Otherwise: counter increments, saturating.
- stall_m = (IDLE & acc & !dmem_ready) | (WAIT & !dmem_ready & !timeout). It is combinational; a zero-wait access never stalls.
- Bubble: while stalled, each edge loads W with valid_w = 0, reg_write_w = 0, bus_err_w = 0; other W fields hold.
- flush_w: at the next edge W loads a bubble regardless of other events.
  - A flush never cancels a bus transaction in progress; WAIT continues.
  - The completing entry is still squashed if flush_w = 1 on its completion edge.
- Stores, offset o = addr[1:0]:
  - SB (000): be = 0001 << o; wdata = byte replicated x4.
  - SH (001): be = 0011 << (2·o[1]); wdata = half replicated x2.
  - SW (010): be = 1111.
  - Loads drive be = 1111, we = 0.
- Loads: select the lane by o, then extend.
  - LB 000 / LH 001: sign-extend.
  - LBU 100 / LHU 101: zero-extend.
  - LW 010: full word.
  - Any other funct3: full word.
- read_data_w updates only on load completion and otherwise holds its last value.
- Misalignment without the optional feature: the low bit is ignored for halfword selection (o[0] dropped); word accesses ignore o.
- Mid-operation reset returns the block to IDLE immediately and drops dmem_req asynchronously.

Optional Feature:
- MEM_MISALIGN_CHECK_EN defined:
  - adds output misalign_w (1 bit, reset 0).
  - A halfword access with o[0] = 1, or a word access with o != 0, issues no dmem_req.
  - W loads the entry with reg_write_w = 0 and misalign_w = 1 in the same cycle, with no stall.
- Undefined: no port, behaviour as above.

Decomposition:
- Shared package/header mem_pkg:
  - funct3 codes (F3_LB..F3_LHU)
  - ResultSrc codes
  - FSM state encodings ST_IDLE / ST_WAIT
- Sub-module mem_lane_fmt (combinational):
  - store path: be + wdata generation
  - load path: lane select + extension
  - Instantiated once and used for both paths.

Test Plan:
- Zero-wait SW to 0x100 with data 0xDEADBEEF, ready held 1 -> dmem_be=1111, stall_m never 1, W fields valid on the next edge.
- SB 0xA5 to 0x103, ready after 3 cycles -> be=1000, wdata=0xA5A5A5A5, stall_m high exactly 3 cycles, 3 bubbles then valid_w=1; addr/be stable throughout WAIT.
- rdata=0x80F07F01 at addr offset 2: LH -> read_data_w=0xFFFF80F0; LHU -> 0x000080F0; LB at offset 1 -> 0x0000007F; LB at offset 3 -> 0xFFFFFF80.
- TIMEOUT_CYC=4, ready never asserted on a load -> after 4 WAIT cycles bus_err_w=1, reg_write_w=0, stall_m drops, next instruction proceeds.
- flush_w asserted on the completion edge of a 2-cycle load -> valid_w=0 and reg_write_w=0 on that edge; rst pulsed mid-WAIT -> dmem_req=0 and all W outputs 0 immediately.
- MEM_MISALIGN_CHECK_EN: LW at 0x102 -> no dmem_req, misalign_w=1, reg_write_w=0, no stall.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared codes for the MEM stage: funct3 access sizes, ResultSrc selects and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: store byte enables/replicated data and load lane select with extension.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    unique case (funct3_i)
      F3_SB: begin
        st_be_o    = 4'b0001 << off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      F3_SH: begin
        // Halfword lane is chosen by off[1] only; off[0] is ignored.
        st_be_o    = 4'b0011 << {off_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata_i[7:0];
    unique case (off_i)
      2'd0: ld_byte = rdata_i[7:0];
      2'd1: ld_byte = rdata_i[15:8];
      2'd2: ld_byte = rdata_i[23:16];
      2'd3: ld_byte = rdata_i[31:24];
      default: ;
    endcase
    ld_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ld_data_o = rdata_i;
    unique case (funct3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data_o = {24'h0, ld_byte};
      F3_LHU:  ld_data_o = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage with req/ready data-memory handshake, stall, flush, timeout and MEM/WB register.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses are dropped and flagged.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned RES_SRC_W   = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic                  reg_write_m,
  input  logic [RES_SRC_W-1:0]  result_src_m,
  input  logic                  mem_read_m,
  input  logic                  mem_write_m,
  input  logic [2:0]            funct3_m,
  input  logic [31:0]           alu_result_m,
  input  logic [31:0]           write_data_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [31:0]           pc_plus4_m,
  input  logic                  flush_w,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ready,
  input  logic [31:0]           dmem_rdata,
  output logic                  stall_m,
  output logic                  valid_w,
  output logic                  reg_write_w,
  output logic [RES_SRC_W-1:0]  result_src_w,
  output logic [31:0]           alu_result_w,
  output logic [31:0]           read_data_w,
  output logic [31:0]           pc_plus4_w,
  output logic [REG_ADDR_W-1:0] rd_w,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                  misalign_w,
`endif
  output logic                  bus_err_w
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC : 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  mem_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [31:0]           h_alu_q, h_alu_d, h_wdata_q, h_wdata_d, h_pc4_q, h_pc4_d;
  logic [3:0]            h_be_q, h_be_d;
  logic                  h_we_q, h_we_d, h_read_q, h_read_d, h_rw_q, h_rw_d;
  logic [2:0]            h_f3_q, h_f3_d;
  logic [RES_SRC_W-1:0]  h_res_q, h_res_d;
  logic [REG_ADDR_W-1:0] h_rd_q, h_rd_d;

  logic                  valid_d, reg_write_d, bus_err_d;
  logic [RES_SRC_W-1:0]  result_src_d;
  logic [31:0]           alu_result_d, read_data_d, pc_plus4_d;
  logic [REG_ADDR_W-1:0] rd_d;

  logic                  acc, misalign, timeout, in_wait;
  logic [2:0]            fmt_f3;
  logic [1:0]            fmt_off;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata, ld_data;

  assign acc     = valid_m & (mem_read_m | mem_write_m);
  assign in_wait = (state_q == ST_WAIT);

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign = acc & (((funct3_m[1:0] == 2'b01) & alu_result_m[0]) |
                           (funct3_m[1] & (|alu_result_m[1:0])));
  assign misalign_w = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign timeout = (TIMEOUT_CYC != 0) && in_wait && !dmem_ready &&
                   (cnt_q == CntW'(TIMEOUT_CYC));

  // In WAIT the formatter sees the held access so the returning word is decoded correctly.
  assign fmt_f3  = in_wait ? h_f3_q : funct3_m;
  assign fmt_off = in_wait ? h_alu_q[1:0] : alu_result_m[1:0];

  mem_lane_fmt u_fmt (
    .funct3_i  (fmt_f3),
    .off_i     (fmt_off),
    .st_data_i (write_data_m),
    .rdata_i   (dmem_rdata),
    .st_be_o   (st_be),
    .st_wdata_o(st_wdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    if (in_wait) begin
      dmem_req   = 1'b1;
      dmem_we    = h_we_q;
      dmem_addr  = {h_alu_q[ADDR_W-1:2], 2'b00};
      dmem_wdata = h_wdata_q;
      dmem_be    = h_be_q;
    end else begin
      dmem_req   = acc & ~misalign;
      dmem_we    = mem_write_m;
      dmem_addr  = {alu_result_m[ADDR_W-1:2], 2'b00};
      dmem_wdata = st_wdata;
      dmem_be    = mem_write_m ? st_be : 4'b1111;
    end
    // Request must fall as soon as reset is asserted, even with an access on the M inputs.
    dmem_req = dmem_req & rst;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    h_alu_d      = h_alu_q;
    h_wdata_d    = h_wdata_q;
    h_pc4_d      = h_pc4_q;
    h_be_d       = h_be_q;
    h_we_d       = h_we_q;
    h_read_d     = h_read_q;
    h_rw_d       = h_rw_q;
    h_f3_d       = h_f3_q;
    h_res_d      = h_res_q;
    h_rd_d       = h_rd_q;
    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    bus_err_d    = 1'b0;
    result_src_d = result_src_w;
    alu_result_d = alu_result_w;
    read_data_d  = read_data_w;
    pc_plus4_d   = pc_plus4_w;
    rd_d         = rd_w;
    stall_m      = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (acc && !misalign && !dmem_ready) begin
          stall_m   = 1'b1;
          state_d   = ST_WAIT;
          cnt_d     = CntW'(1);
          h_alu_d   = alu_result_m;
          h_wdata_d = dmem_wdata;
          h_be_d    = dmem_be;
          h_we_d    = mem_write_m;
          h_read_d  = mem_read_m;
          h_rw_d    = reg_write_m;
          h_f3_d    = funct3_m;
          h_res_d   = result_src_m;
          h_rd_d    = rd_m;
          h_pc4_d   = pc_plus4_m;
        end else begin
          valid_d      = valid_m;
          reg_write_d  = reg_write_m & ~misalign;
          result_src_d = result_src_m;
          alu_result_d = alu_result_m;
          pc_plus4_d   = pc_plus4_m;
          rd_d         = rd_m;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_d   = misalign;
`endif
          if (acc && !misalign && mem_read_m) read_data_d = ld_data;
        end
      end
      ST_WAIT: begin
        if (dmem_ready || timeout) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          valid_d      = 1'b1;
          reg_write_d  = h_rw_q & dmem_ready;
          bus_err_d    = ~dmem_ready;
          result_src_d = h_res_q;
          alu_result_d = h_alu_q;
          pc_plus4_d   = h_pc4_q;
          rd_d         = h_rd_q;
          if (dmem_ready && h_read_q) read_data_d = ld_data;
        end else begin
          stall_m = 1'b1;
          if (cnt_q != CntW'(CntMax)) cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush squashes the W entry but leaves the bus transaction and hold regs alone.
    if (flush_w) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      bus_err_d    = 1'b0;
      result_src_d = result_src_w;
      alu_result_d = alu_result_w;
      read_data_d  = read_data_w;
      pc_plus4_d   = pc_plus4_w;
      rd_d         = rd_w;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      h_alu_q      <= '0;
      h_wdata_q    <= '0;
      h_pc4_q      <= '0;
      h_be_q       <= '0;
      h_we_q       <= 1'b0;
      h_read_q     <= 1'b0;
      h_rw_q       <= 1'b0;
      h_f3_q       <= '0;
      h_res_q      <= '0;
      h_rd_q       <= '0;
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      bus_err_w    <= 1'b0;
      result_src_w <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      h_alu_q      <= h_alu_d;
      h_wdata_q    <= h_wdata_d;
      h_pc4_q      <= h_pc4_d;
      h_be_q       <= h_be_d;
      h_we_q       <= h_we_d;
      h_read_q     <= h_read_d;
      h_rw_q       <= h_rw_d;
      h_f3_q       <= h_f3_d;
      h_res_q      <= h_res_d;
      h_rd_q       <= h_rd_d;
      valid_w      <= valid_d;
      reg_write_w  <= reg_write_d;
      bus_err_w    <= bus_err_d;
      result_src_w <= result_src_d;
      alu_result_w <= alu_result_d;
      read_data_w  <= read_data_d;
      pc_plus4_w   <= pc_plus4_d;
      rd_w         <= rd_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: stores, loads, wait states, timeout, flush, reset.
module tb_mem_stage_hs;
  import mem_pkg::*;

  logic        clk, rst;
  logic        valid_m, reg_write_m, mem_read_m, mem_write_m, flush_w;
  logic [1:0]  result_src_m, result_src_w;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m, rd_w;
  logic        dmem_req, dmem_we, dmem_ready, stall_m;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        valid_w, reg_write_w, bus_err_w;
  logic [31:0] alu_result_w, read_data_w, pc_plus4_w;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_w;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;

  mem_stage_hs #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .flush_w(flush_w), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall_m(stall_m), .valid_w(valid_w),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w), .rd_w(rd_w),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_w(misalign_w),
`endif
    .bus_err_w(bus_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    valid_m = 1'b1; mem_read_m = ld; mem_write_m = ~ld; reg_write_m = ld;
    result_src_m = ld ? RES_LOAD : RES_ALU; funct3_m = f3; alu_result_m = addr;
    write_data_m = wd; pc_plus4_m = 32'h1000 + addr; rd_m = 5'd9;
  endtask

  task automatic set_alu(input logic [31:0] res);
    valid_m = 1'b1; mem_read_m = 1'b0; mem_write_m = 1'b0; reg_write_m = 1'b1;
    result_src_m = RES_ALU; funct3_m = 3'b000; alu_result_m = res;
    write_data_m = 32'h0; pc_plus4_m = 32'h2000; rd_m = 5'd4;
  endtask

  task automatic set_idle();
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; reg_write_m = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush_w = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    set_mem(1'b1, F3_LW, 32'h40, 32'h0);
    #3;
    check_eq("rst_valid_w", valid_w, 0);
    check_eq("rst_reg_write_w", reg_write_w, 0);
    check_eq("rst_alu_result_w", alu_result_w, 0);
    check_eq("rst_read_data_w", read_data_w, 0);
    check_eq("rst_bus_err_w", bus_err_w, 0);
    check_eq("rst_dmem_req", dmem_req, 0);
    set_idle();
    step();
    rst = 1'b1;

    // Zero-wait SW
    set_mem(1'b0, F3_SW, 32'h100, 32'hDEADBEEF);
    dmem_ready = 1'b1;
    #2;
    check_eq("sw_req", dmem_req, 1);
    check_eq("sw_we", dmem_we, 1);
    check_eq("sw_be", dmem_be, 4'b1111);
    check_eq("sw_addr", dmem_addr, 32'h100);
    check_eq("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check_eq("sw_stall", stall_m, 0);
    step();
    check_eq("sw_valid_w", valid_w, 1);
    check_eq("sw_alu_w", alu_result_w, 32'h100);
    check_eq("sw_pc4_w", pc_plus4_w, 32'h1100);
    check_eq("sw_rw_w", reg_write_w, 0);

    // SB with three wait cycles; M inputs change mid-WAIT and must not leak out
    set_mem(1'b0, F3_SB, 32'h103, 32'h000000A5);
    dmem_ready = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) set_mem(1'b0, F3_SW, 32'h200, 32'h11223344);
      if (i == 3) dmem_ready = 1'b1;
      #2;
      stall_cnt += int'(stall_m);
      check_eq("sb_be", dmem_be, 4'b1000);
      check_eq("sb_addr", dmem_addr, 32'h100);
      check_eq("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
      step();
      check_eq("sb_valid_w", valid_w, (i == 3) ? 1 : 0);
    end
    check_eq("sb_stall_cycles", stall_cnt, 3);
    check_eq("sb_alu_w", alu_result_w, 32'h103);
    check_eq("sb_pc4_w", pc_plus4_w, 32'h1103);

    // Zero-wait sub-word loads
    dmem_rdata = 32'h80F07F01;
    set_mem(1'b1, F3_LH, 32'h102, 32'h0);
    step();
    check_eq("lh_data", read_data_w, 32'hFFFF80F0);
    check_eq("lh_rw", reg_write_w, 1);
    check_eq("lh_rd", rd_w, 9);
    check_eq("lh_res", result_src_w, RES_LOAD);
    set_mem(1'b1, F3_LHU, 32'h102, 32'h0);
    step();
    check_eq("lhu_data", read_data_w, 32'h000080F0);
    set_mem(1'b1, F3_LW, 32'h104, 32'h0);
    step();
    check_eq("lw_data", read_data_w, 32'h80F07F01);
    set_mem(1'b1, F3_LB, 32'h101, 32'h0);
    step();
    check_eq("lb1_data", read_data_w, 32'h0000007F);
    set_mem(1'b1, F3_LB, 32'h103, 32'h0);
    step();
    check_eq("lb3_data", read_data_w, 32'hFFFFFF80);
    set_alu(32'h55);
    #2;
    check_eq("alu_req", dmem_req, 0);
    step();
    check_eq("alu_alu_w", alu_result_w, 32'h55);
    check_eq("alu_rd_hold", read_data_w, 32'hFFFFFF80);
    check_eq("alu_res", result_src_w, RES_ALU);

    // Timeout after 4 WAIT cycles
    set_mem(1'b1, F3_LW, 32'h200, 32'h0);
    dmem_ready = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      stall_cnt += int'(stall_m);
      if (i == 4) check_eq("to_stall_drop", stall_m, 0);
      step();
    end
    check_eq("to_stall_cycles", stall_cnt, 4);
    check_eq("to_bus_err", bus_err_w, 1);
    check_eq("to_rw", reg_write_w, 0);
    check_eq("to_valid", valid_w, 1);
    check_eq("to_alu_w", alu_result_w, 32'h200);
    set_alu(32'h77);
    step();
    check_eq("to_next_valid", valid_w, 1);
    check_eq("to_next_bus_err", bus_err_w, 0);
    check_eq("to_next_rw", reg_write_w, 1);
    check_eq("to_next_alu", alu_result_w, 32'h77);

    // Flush while entering WAIT does not cancel the transaction
    set_mem(1'b1, F3_LW, 32'h300, 32'h0);
    dmem_rdata = 32'hCAFEF00D;
    flush_w = 1'b1;
    step();
    flush_w = 1'b0;
    #2;
    check_eq("fl_wait_req", dmem_req, 1);
    check_eq("fl_wait_addr", dmem_addr, 32'h300);
    step();
    dmem_ready = 1'b1;
    step();
    check_eq("fl_wait_valid", valid_w, 1);
    check_eq("fl_wait_data", read_data_w, 32'hCAFEF00D);

    // Flush on the completion edge of a 2-cycle load
    dmem_ready = 1'b0;
    dmem_rdata = 32'h12345678;
    set_mem(1'b1, F3_LW, 32'h400, 32'h0);
    step();
    dmem_ready = 1'b1;
    flush_w = 1'b1;
    step();
    flush_w = 1'b0;
    check_eq("fl_cmp_valid", valid_w, 0);
    check_eq("fl_cmp_rw", reg_write_w, 0);
    check_eq("fl_cmp_data_hold", read_data_w, 32'hCAFEF00D);
    check_eq("fl_cmp_alu_hold", alu_result_w, 32'h300);

    // Reset pulsed mid-WAIT
    dmem_ready = 1'b0;
    set_mem(1'b1, F3_LW, 32'h500, 32'h0);
    step();
    step();
    #2;
    check_eq("mr_req_before", dmem_req, 1);
    rst = 1'b0;
    #1;
    check_eq("mr_req", dmem_req, 0);
    check_eq("mr_valid_w", valid_w, 0);
    check_eq("mr_alu_w", alu_result_w, 0);
    check_eq("mr_read_data_w", read_data_w, 0);
    check_eq("mr_pc4_w", pc_plus4_w, 0);
    rst = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check_eq("mr_idle_stall", stall_m, 0);
    step();
    check_eq("mr_idle_valid", valid_w, 1);
    check_eq("mr_idle_data", read_data_w, 32'h12345678);

`ifdef MEM_MISALIGN_CHECK_EN
    dmem_ready = 1'b0;
    set_mem(1'b1, F3_LW, 32'h102, 32'h0);
    #2;
    check_eq("ma_req", dmem_req, 0);
    check_eq("ma_stall", stall_m, 0);
    step();
    check_eq("ma_flag", misalign_w, 1);
    check_eq("ma_rw", reg_write_w, 0);
    check_eq("ma_valid", valid_w, 1);
    set_alu(32'h9);
    step();
    check_eq("ma_clear", misalign_w, 0);
`endif

    set_idle();
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
